// File: rtl/program_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer_pkg
// Description : Shared definitions for the accumulator-processor program
//               sequencer: default field widths, the halt opcode and the
//               fetch/execute state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package program_sequencer_pkg;

  localparam int ADDR_LEN   = 11;
  localparam int OPCODE_LEN = 5;
  localparam int INSTR_LEN  = 16;

  localparam logic [OPCODE_LEN-1:0] HLT_OPCODE = 5'b00000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/program_sequencer_pc.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer_pc
// Description : Program counter register. Loads d_i when en_i is high,
//               otherwise holds. Clears to zero on synchronous reset.
// Ports       : clk_i   - clock
//               reset_i - synchronous active-high reset
//               en_i    - load enable
//               d_i     - next program counter value
//               q_o     - current program counter value
// Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer_pc #(
  parameter int ADDR_LEN = program_sequencer_pkg::ADDR_LEN
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                en_i,
  input  logic [ADDR_LEN-1:0] d_i,
  output logic [ADDR_LEN-1:0] q_o
);

  logic [ADDR_LEN-1:0] pc_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc_q <= '0;
    end else if (en_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : program_sequencer
// Description : Fetch/execute sequencer for the accumulator processor. Owns
//               the program counter, drives the instruction-memory address
//               and presents each fetched instruction to the datapath for
//               one cycle. Supports free-running (run) and single-step
//               (step) execution and stops permanently on the halt opcode.
// Ports       : clk_i          - clock, rising edge
//               reset_i        - synchronous active-high reset
//               run_i          - level, execute continuously while high
//               step_i         - one-cycle pulse, execute one instruction
//               instr_data_i   - instruction memory read data
//               pc_addr_o      - program counter / memory address
//               instr_o        - instruction for the datapath
//               instr_valid_o  - instr_o is to be executed this cycle
//               halted_o       - halt opcode has been executed
//               busy_o         - fetch or execute in progress
//               instr_count_o  - executed non-halt instructions, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int                    ADDR_LEN   = program_sequencer_pkg::ADDR_LEN,
  parameter int                    OPCODE_LEN = program_sequencer_pkg::OPCODE_LEN,
  parameter int                    INSTR_LEN  = program_sequencer_pkg::INSTR_LEN,
  parameter logic [OPCODE_LEN-1:0] HLT_OPCODE = program_sequencer_pkg::HLT_OPCODE
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 run_i,
  input  logic                 step_i,
  input  logic [INSTR_LEN-1:0] instr_data_i,
  output logic [ADDR_LEN-1:0]  pc_addr_o,
  output logic [INSTR_LEN-1:0] instr_o,
  output logic                 instr_valid_o,
  output logic                 halted_o,
  output logic                 busy_o,
  output logic [31:0]          instr_count_o
);

  state_e                state_q;
  state_e                state_d;
  logic [INSTR_LEN-1:0]  instr_q;
  logic [31:0]           count_q;
  logic [ADDR_LEN-1:0]   pc_q;
  logic [ADDR_LEN-1:0]   pc_next;
  logic                  in_exec;
  logic                  is_hlt;
  logic                  advance;

  assign in_exec = (state_q == EXEC);
  assign is_hlt  = (instr_data_i[INSTR_LEN-1 -: OPCODE_LEN] == HLT_OPCODE);
  // A non-halt instruction retires: move the PC and bump the counter.
  assign advance = in_exec && !is_hlt;
  // Natural wrap at 2^ADDR_LEN comes from the fixed result width.
  assign pc_next = pc_q + {{(ADDR_LEN-1){1'b0}}, 1'b1};

  program_sequencer_pc #(
    .ADDR_LEN (ADDR_LEN)
  ) u_pc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (advance),
    .d_i     (pc_next),
    .q_o     (pc_q)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Steps arriving in FETCH/EXEC are not remembered, so
  // they are simply dropped; run is re-sampled only at the end of EXEC.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (run_i || step_i) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = EXEC;
      end
      EXEC: begin
        if (is_hlt) begin
          state_d = HALT;
        end else if (run_i) begin
          state_d = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Instruction latch and retired-instruction counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      instr_q <= '0;
    end else if (in_exec) begin
      instr_q <= instr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (advance && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  // Memory data arrives during EXEC, so the datapath sees it directly in
  // that cycle; the latched copy holds it afterwards.
  assign instr_o       = in_exec ? instr_data_i : instr_q;
  assign instr_valid_o = in_exec;
  assign halted_o      = (state_q == HALT);
  assign busy_o        = (state_q == FETCH) || in_exec;
  assign pc_addr_o     = pc_q;
  assign instr_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_sequencer
// Description : Self-checking bench for program_sequencer. Expected executed
//               instructions are queued when stimulus is issued; a monitor
//               pops and compares on every instr_valid strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_sequencer;

  typedef struct packed {
    logic [15:0] instr;
    logic [10:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        run_i;
  logic        step_i;
  logic [15:0] mem_rd;
  logic [10:0] pc_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic        halted;
  logic        busy;
  logic [31:0] instr_count;

  logic [15:0] mem [0:2047];
  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  // Synchronous instruction memory: data for an address appears one cycle later.
  always @(posedge clk) mem_rd <= mem[pc_addr];

  program_sequencer dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .run_i         (run_i),
    .step_i        (step_i),
    .instr_data_i  (mem_rd),
    .pc_addr_o     (pc_addr),
    .instr_o       (instr),
    .instr_valid_o (instr_valid),
    .halted_o      (halted),
    .busy_o        (busy),
    .instr_count_o (instr_count)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic expect_instr(input int a);
    exp_t e;
    e.instr = mem[a];
    e.pc    = a[10:0];
    exp_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"},     32'(pc_addr), 32'd0);
    check({tag, "_instr"},  32'(instr), 32'd0);
    check({tag, "_valid"},  32'(instr_valid), 32'd0);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_busy"},   32'(busy), 32'd0);
    check({tag, "_count"},  instr_count, 32'd0);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    run_i   = 1'b0;
    step_i  = 1'b0;
    tick(2);
    reset_i = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got instr=%h pc=%0d, required no instr_valid", instr, pc_addr);
        end else begin
          e = exp_q.pop_front();
          check("valid_instr", 32'(instr), 32'(e.instr));
          check("valid_pc", 32'(pc_addr), 32'(e.pc));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    run_i   = 1'b0;
    step_i  = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      mem[i] = {5'b00001, 11'(i)};
    end
    mem[0] = 16'h0801;
    fork
      monitor();
    join_none

    // Reset state
    tick(2);
    reset_i = 1'b0;
    check_reset("reset");

    // Single step; a second step during EXEC must be dropped
    step_i = 1'b1;
    expect_instr(0);
    tick(1);
    step_i = 1'b0;
    check("step_fetch_pc", 32'(pc_addr), 32'd0);
    check("step_fetch_busy", 32'(busy), 32'd1);
    tick(1);
    step_i = 1'b1;
    tick(1);
    step_i = 1'b0;
    check("step_pc", 32'(pc_addr), 32'd1);
    check("step_count", instr_count, 32'd1);
    check("step_idle_busy", 32'(busy), 32'd0);
    check("step_instr_hold", 32'(instr), 32'h0801);
    tick(3);
    check("step_drop_count", instr_count, 32'd1);

    // Continuous run to HLT
    mem[1] = 16'h1234;
    mem[2] = 16'hF00F;
    mem[3] = 16'h0802;
    mem[4] = 16'h0123;
    do_reset();
    run_i = 1'b1;
    for (int i = 0; i < 5; i++) expect_instr(i);
    tick(11);
    check("run_halted", 32'(halted), 32'd1);
    check("run_pc", 32'(pc_addr), 32'd4);
    check("run_count", instr_count, 32'd4);
    check("run_busy", 32'(busy), 32'd0);
    check("run_instr_hold", 32'(instr), 32'h0123);
    check("run_drained", 32'(exp_q.size()), 32'd0);
    step_i = 1'b1;
    tick(1);
    step_i = 1'b0;
    tick(4);
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_pc", 32'(pc_addr), 32'd4);
    check("halt_count", instr_count, 32'd4);

    // Reset during HALT, then step from address 0
    reset_i = 1'b1;
    tick(1);
    check_reset("rst_halt");
    reset_i = 1'b0;
    run_i   = 1'b0;
    step_i  = 1'b1;
    expect_instr(0);
    tick(1);
    step_i = 1'b0;
    tick(2);
    check("after_halt_pc", 32'(pc_addr), 32'd1);
    check("after_halt_count", instr_count, 32'd1);

    // Reset during FETCH aborts the fetch
    step_i = 1'b1;
    tick(1);
    step_i  = 1'b0;
    reset_i = 1'b1;
    tick(1);
    check_reset("rst_fetch");
    reset_i = 1'b0;
    tick(3);
    check("abort_pc", 32'(pc_addr), 32'd0);
    check("abort_count", instr_count, 32'd0);
    step_i = 1'b1;
    expect_instr(0);
    tick(1);
    step_i = 1'b0;
    tick(2);
    check("abort_step_pc", 32'(pc_addr), 32'd1);

    // run and step together, extra step while busy
    mem[3] = 16'h07FF;
    do_reset();
    run_i  = 1'b1;
    step_i = 1'b1;
    for (int i = 0; i < 4; i++) expect_instr(i);
    tick(1);
    step_i = 1'b0;
    tick(1);
    step_i = 1'b1;
    tick(1);
    step_i = 1'b0;
    tick(6);
    check("both_halted", 32'(halted), 32'd1);
    check("both_pc", 32'(pc_addr), 32'd3);
    check("both_count", instr_count, 32'd3);
    check("both_drained", 32'(exp_q.size()), 32'd0);

    // Run through the whole address space; drop run in FETCH of 2047
    mem[3]    = 16'h0803;
    mem[4]    = 16'h0804;
    mem[2047] = 16'hABCD;
    do_reset();
    run_i = 1'b1;
    for (int i = 0; i < 2048; i++) expect_instr(i);
    tick(4095);
    check("wrap_fetch_pc", 32'(pc_addr), 32'd2047);
    check("wrap_fetch_busy", 32'(busy), 32'd1);
    run_i = 1'b0;
    tick(2);
    check("wrap_pc", 32'(pc_addr), 32'd0);
    check("wrap_count", instr_count, 32'd2048);
    check("wrap_idle_busy", 32'(busy), 32'd0);
    check("wrap_halted", 32'(halted), 32'd0);
    check("wrap_drained", 32'(exp_q.size()), 32'd0);
    tick(3);
    check("wrap_idle_count", instr_count, 32'd2048);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Fetch/execute sequencer for the accumulator processor. It owns the program counter and drives the instruction-memory address, then presents each fetched instruction to the datapath for one cycle. It supports free-running and single-step execution and stops on the HLT opcode. It sits between the debug/run control and the instruction memory, replacing the always-enabled PC + adder pair.

Parameters:
ADDR_LEN, 11, program counter / instruction memory address width
OPCODE_LEN, 5, opcode field width (instr[INSTR_LEN-1 -: OPCODE_LEN])
INSTR_LEN, 16, instruction word width
HLT_OPCODE, 5'b00000, opcode that halts execution

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
run  in  1  level; while high, execute continuously
step  in  1  one-cycle pulse; execute exactly one instruction
instr_data  in  INSTR_LEN  instruction memory read data; valid 1 cycle after pc_addr is presented
pc_addr  out  ADDR_LEN  program counter / instruction memory address
instr  out  INSTR_LEN  latched instruction for the datapath
instr_valid  out  1  one-cycle strobe: instr is to be executed this cycle
halted  out  1  high once HLT has been executed
busy  out  1  high in FETCH and EXEC
instr_count  out  32  executed non-HLT instructions, saturating

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-fetch): pc_addr=0, instr=0, instr_valid=0, halted=0, busy=0, instr_count=0, state=IDLE.
- States: IDLE, FETCH, EXEC, HALT. State is encoded in 2 bits.
- IDLE:
  - If run=1 or step=1, go to FETCH. When both are high, run wins and step is ignored.
  - Otherwise stay in IDLE. pc_addr holds its value.
- FETCH:
  - Lasts one cycle; pc_addr is stable and the memory read is in flight. busy=1.
  - Go to EXEC.
- EXEC:
  - On entry, instr <= instr_data and instr_valid=1 for exactly this cycle.
  - If the opcode equals HLT_OPCODE: go to HALT, set halted=1, leave pc_addr unchanged, leave instr_count unchanged.
  - Otherwise:
    - pc_addr <= pc_addr+1, modulo 2^ADDR_LEN, so 2047 wraps to 0.
    - instr_count <= instr_count+1, saturating at 32'hFFFFFFFF.
    - Next state is FETCH if run=1, else IDLE.
- HALT:
  - Terminal state. run and step are ignored; only reset exits.
  - instr_valid=0, busy=0, halted=1.
- Latency: in run mode, one instruction every 2 cycles. For a step, instr_valid rises 2 cycles after the step pulse is sampled.
- step pulses arriving while busy=1 are dropped, not queued.
- Dropping run during FETCH still completes the current instruction, then returns to IDLE.
- instr holds its last value outside EXEC. The datapath must qualify it with instr_valid.

Decomposition:
- Shared package/header holds: state encodings (IDLE=0, FETCH=1, EXEC=2, HALT=3), HLT_OPCODE, and the default widths ADDR_LEN, OPCODE_LEN, INSTR_LEN.
- Natural sub-module: the existing pc register, instantiated with enable driven by the EXEC non-HLT condition and next value pc+1.
- The FSM and instr_count stay inline.

Test Plan:
- Reset, then step pulse at cycle 0 with mem[0]=16'h0801: pc_addr=0 during FETCH; instr=16'h0801 and instr_valid=1 at cycle 2; pc_addr=1, instr_count=1 at cycle 3; state IDLE.
- run held high with mem[0..3] non-HLT and mem[4]=HLT: instr_valid pulses at cycles 2, 4, 6, 8, 10; halted=1 after cycle 10; pc_addr stays 4; instr_count=4; further run/step cause no activity.
- Preload pc to 2047 via run, mem[2047] non-HLT: after EXEC, pc_addr=0 and instr_count increments.
- run and step asserted together, then step pulsed while busy: behaves as continuous run; the extra step produces no extra instr_valid.
- reset asserted during FETCH and during HALT: next cycle all outputs are at reset values and state is IDLE; a subsequent step fetches address 0.
- run deasserted during FETCH: exactly one more instr_valid, then IDLE with pc incremented.
